// File: rtl/snake_length_ctrl_pkg.sv
// Shared game-state encoding and length width for the snake controller
// and the LED bar decoder.
package snake_length_ctrl_pkg;

   localparam int LEN_W       = 3;
   localparam int LEN_MAX_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

endpackage

// File: rtl/snake_tick_div.sv
// Move-tick divider: one-cycle pulse every `period` enabled cycles.
module snake_tick_div #(
   parameter int CNT_W = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             clear,
   input  logic [CNT_W-1:0] period,
   output logic             tick
);

   logic [CNT_W-1:0] cnt;

   // >= so a shrinking period still fires promptly instead of wrapping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (!enable || clear) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt >= period - CNT_W'(1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + CNT_W'(1);
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/snake_length_ctrl.sv
// Snake game-progress controller: length count, game FSM and move tick.
// Define SNAKE_LIVES_EN to give the player three lives.
module snake_length_ctrl
   import snake_length_ctrl_pkg::*;
#(
   parameter int MAX_LEN  = LEN_MAX_DEF,
   parameter int BASE_DIV = 25_000_000,
   parameter int STEP_DIV = 3_000_000,
   parameter int CNT_W    = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             eat,
   input  logic             collide,
   output logic [LEN_W-1:0] length,
   output logic [1:0]       state,
   output logic             move_tick,
   output logic             game_over,
   output logic             win,
   output logic [1:0]       lives
);

   localparam logic [LEN_W-1:0] LEN_TOP = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] BASE    = CNT_W'(BASE_DIV);
   localparam logic [CNT_W-1:0] STEP    = CNT_W'(STEP_DIV);
`ifdef SNAKE_LIVES_EN
   localparam logic [1:0] LIVES_FULL = 2'd3;
`else
   localparam logic [1:0] LIVES_FULL = 2'd1;
`endif

   state_t           st, st_n;
   logic [LEN_W-1:0] len, len_n;
   logic [1:0]       lv, lv_n;
   logic             start_q, eat_q, collide_q;
   logic             start_ev, eat_ev, collide_ev;
   logic             tick_clr;
   logic [CNT_W-1:0] period;

   assign start_ev   = start & ~start_q;
   assign eat_ev     = eat & ~eat_q;
   assign collide_ev = collide & ~collide_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= ST_IDLE;
         len       <= '0;
         lv        <= LIVES_FULL;
         start_q   <= 1'b0;
         eat_q     <= 1'b0;
         collide_q <= 1'b0;
      end else begin
         st        <= st_n;
         len       <= len_n;
         lv        <= lv_n;
         start_q   <= start;
         eat_q     <= eat;
         collide_q <= collide;
      end
   end

   always_comb begin
      st_n     = st;
      len_n    = len;
      lv_n     = lv;
      tick_clr = 1'b0;
      unique case (st)
         ST_IDLE: begin
            if (start_ev) begin
               st_n     = ST_PLAY;
               len_n    = '0;
               tick_clr = 1'b1;
            end
         end
         ST_PLAY: begin
            // collide has priority and suppresses a coincident eat
            if (collide_ev) begin
`ifdef SNAKE_LIVES_EN
               if (lv > 2'd1) begin
                  lv_n     = lv - 2'd1;
                  tick_clr = 1'b1;
               end else begin
                  lv_n = 2'd0;
                  st_n = ST_OVER;
               end
`else
               st_n = ST_OVER;
`endif
            end else if (eat_ev) begin
               if (len < LEN_TOP) begin
                  len_n = len + LEN_W'(1);
               end
               if (len_n == LEN_TOP) begin
                  st_n = ST_WIN;
               end
            end
         end
         ST_WIN, ST_OVER: begin
            if (start_ev) begin
               st_n     = ST_PLAY;
               len_n    = '0;
               lv_n     = LIVES_FULL;
               tick_clr = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign period = BASE - CNT_W'(len) * STEP;

   snake_tick_div #(
      .CNT_W (CNT_W)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .enable (st == ST_PLAY),
      .clear  (tick_clr),
      .period (period),
      .tick   (move_tick)
   );

   assign length    = len;
   assign state     = st;
   assign lives     = lv;
   assign game_over = (st == ST_OVER);
   assign win       = (st == ST_WIN);

endmodule

// File: tb/tb_snake_length_ctrl.sv
// Self-checking bench for snake_length_ctrl (BASE_DIV=10, STEP_DIV=1).
// Build with SNAKE_LIVES_EN defined to exercise the lives variant.
module tb_snake_length_ctrl;

   localparam int SIG_STATE = 0;
   localparam int SIG_LEN   = 1;
   localparam int SIG_WIN   = 2;
   localparam int SIG_OVER  = 3;
   localparam int SIG_LIVES = 4;
   localparam int SIG_TICK  = 5;
`ifdef SNAKE_LIVES_EN
   localparam int LIVES_EN = 1;
`else
   localparam int LIVES_EN = 0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, eat, collide;
   logic [2:0] length;
   logic [1:0] state;
   logic       move_tick, game_over, win;
   logic [1:0] lives;

   snake_length_ctrl #(
      .MAX_LEN  (6),
      .BASE_DIV (10),
      .STEP_DIV (1),
      .CNT_W    (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .eat       (eat),
      .collide   (collide),
      .length    (length),
      .state     (state),
      .move_tick (move_tick),
      .game_over (game_over),
      .win       (win),
      .lives     (lives)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   typedef struct {
      string tag;
      int    sig;
      int    val;
   } exp_t;

   exp_t sb[$];
   int   tick_q[$];
   bit   tick_chk = 1'b0;

   task automatic push(input string tag, input int sig, input int val);
      exp_t e;
      e.tag = tag;
      e.sig = sig;
      e.val = val;
      sb.push_back(e);
   endtask

   function automatic int observe(input int sig);
      case (sig)
         SIG_STATE: return int'(state);
         SIG_LEN:   return int'(length);
         SIG_WIN:   return int'(win);
         SIG_OVER:  return int'(game_over);
         SIG_LIVES: return int'(lives);
         default:   return int'(move_tick);
      endcase
   endfunction

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.sig), e.val);
      end
   endtask

   always @(negedge clk) begin
      if (tick_chk && move_tick) begin
         if (tick_q.size() == 0) check("tick_extra", cyc, -1);
         else check("tick_cycle", cyc, tick_q.pop_front());
      end
   end

   task automatic pulse(input bit s, input bit e, input bit c);
      @(negedge clk);
      start   = s;
      eat     = e;
      collide = c;
      @(negedge clk);
      start   = 1'b0;
      eat     = 1'b0;
      collide = 1'b0;
   endtask

   task automatic wait_tick(output int at);
      int n;
      n  = 0;
      at = -1;
      while (n < 40 && at < 0) begin
         @(negedge clk);
         if (move_tick) at = cyc;
         n++;
      end
      if (at < 0) check("tick_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, t1, t2;
      rst     = 1'b1;
      start   = 1'b0;
      eat     = 1'b0;
      collide = 1'b0;
      repeat (2) @(negedge clk);
      push("rst_state", SIG_STATE, 0);
      push("rst_len", SIG_LEN, 0);
      push("rst_tick", SIG_TICK, 0);
      push("rst_win", SIG_WIN, 0);
      push("rst_over", SIG_OVER, 0);
      push("rst_lives", SIG_LIVES, LIVES_EN ? 3 : 1);
      drain();
      rst = 1'b0;
      @(negedge clk);

      // start, then ticks at 10-cycle spacing
      tick_chk = 1'b1;
      k = cyc;
      start = 1'b1;
      tick_q.push_back(k + 11);
      tick_q.push_back(k + 21);
      tick_q.push_back(k + 31);
      @(negedge clk);
      start = 1'b0;
      push("play_state", SIG_STATE, 1);
      push("play_len", SIG_LEN, 0);
      drain();
      repeat (34) @(negedge clk);
      check("tick_missing", tick_q.size(), 0);

      // six eats to a win
      tick_chk = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         pulse(1'b0, 1'b1, 1'b0);
         push("eat_len", SIG_LEN, i);
         push("eat_state", SIG_STATE, i == 6 ? 2 : 1);
         push("eat_win", SIG_WIN, i == 6 ? 1 : 0);
         drain();
         repeat (2) @(negedge clk);
      end
      tick_q.delete();
      tick_chk = 1'b1;
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      repeat (30) @(negedge clk);
      push("win_len_hold", SIG_LEN, 6);
      push("win_state", SIG_STATE, 2);
      drain();
      tick_chk = 1'b0;

      // held eat counts once; period 7 at length 3
      pulse(1'b1, 1'b0, 1'b0);
      push("restart_state", SIG_STATE, 1);
      push("restart_len", SIG_LEN, 0);
      drain();
      @(negedge clk);
      eat = 1'b1;
      repeat (20) @(negedge clk);
      eat = 1'b0;
      push("held_eat_len", SIG_LEN, 1);
      drain();
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      push("len3", SIG_LEN, 3);
      drain();
      wait_tick(t1);
      wait_tick(t2);
      check("period_len3", t2 - t1, 7);

      // asynchronous reset mid-game
      pulse(1'b0, 1'b1, 1'b0);
      push("len4", SIG_LEN, 4);
      drain();
      #2 rst = 1'b1;
      #1;
      push("arst_state", SIG_STATE, 0);
      push("arst_len", SIG_LEN, 0);
      push("arst_tick", SIG_TICK, 0);
      drain();
      @(negedge clk);
      rst = 1'b0;
      pulse(1'b1, 1'b0, 1'b0);
      push("post_rst_state", SIG_STATE, 1);
      push("post_rst_len", SIG_LEN, 0);
      drain();
      pulse(1'b0, 1'b1, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      push("len2", SIG_LEN, 2);
      drain();

      // eat and collide together: collide wins
      pulse(1'b0, 1'b1, 1'b1);
      push("ec_len", SIG_LEN, 2);
      push("ec_state", SIG_STATE, LIVES_EN ? 1 : 3);
      push("ec_over", SIG_OVER, LIVES_EN ? 0 : 1);
      push("ec_lives", SIG_LIVES, LIVES_EN ? 2 : 1);
      drain();
      if (LIVES_EN != 0) begin
         pulse(1'b0, 1'b0, 1'b1);
         push("life2_lives", SIG_LIVES, 1);
         push("life2_state", SIG_STATE, 1);
         drain();
         pulse(1'b0, 1'b0, 1'b1);
         push("life3_lives", SIG_LIVES, 0);
         push("life3_state", SIG_STATE, 3);
         push("life3_over", SIG_OVER, 1);
         push("life3_len", SIG_LEN, 2);
         drain();
      end
      pulse(1'b0, 1'b1, 1'b0);
      push("over_len_hold", SIG_LEN, 2);
      drain();
      pulse(1'b1, 1'b0, 1'b0);
      push("replay_state", SIG_STATE, 1);
      push("replay_len", SIG_LEN, 0);
      push("replay_lives", SIG_LIVES, LIVES_EN ? 3 : 1);
      push("replay_over", SIG_OVER, 0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
